// File: rtl/tri_bbox_scanner.sv
// Purpose : clamps a signed triangle bounding box to the display and walks every pixel in raster order.
// Latency : box accept -> first pixel 1 cycle; last pixel transfer -> done 1 cycle; done -> bbox_ready 1 cycle.
// Backpres: px_ready low holds px_* stable with no advance; bbox_ready is high only while idle.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   bbox_valid / bbox_ready      box handshake; min_x/min_y/max_x/max_y sampled only at accept
//   px_valid / px_ready          pixel handshake; px_x, px_y, px_last qualified by px_valid
//   done                         one-cycle pulse when a box is finished (including an empty box)
//   pix_count                    pixels transferred for the current/last box
//                                (present only when TRI_BBOX_SCAN_COUNT_EN is defined)
module tri_bbox_scanner #(
    parameter int DISPLAY_WIDTH  = 100,
    parameter int DISPLAY_HEIGHT = 100,
    localparam int XW = $clog2(DISPLAY_WIDTH),
    localparam int YW = $clog2(DISPLAY_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bbox_valid,
    output logic                 bbox_ready,
    input  logic signed [31:0]   min_x,
    input  logic signed [31:0]   min_y,
    input  logic signed [31:0]   max_x,
    input  logic signed [31:0]   max_y,
    output logic                 px_valid,
    input  logic                 px_ready,
    output logic [XW-1:0]        px_x,
    output logic [YW-1:0]        px_y,
    output logic                 px_last,
    output logic                 done
`ifdef TRI_BBOX_SCAN_COUNT_EN
    ,
    output logic [31:0]          pix_count
`endif
);

    localparam logic signed [31:0] X_MAX = 32'(DISPLAY_WIDTH - 1);
    localparam logic signed [31:0] Y_MAX = 32'(DISPLAY_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Clamped box limits retained for the scan; px_x/px_y double as the cursor.
    logic [XW-1:0] x0_r;
    logic [XW-1:0] x1_r;
    logic [YW-1:0] y1_r;

    logic signed [31:0] c_x0, c_x1, c_y0, c_y1;
    logic               c_empty;
    logic               accept;
    logic               xfer;
    logic [XW-1:0]      nx;
    logic [YW-1:0]      ny;

    // Clamp in full signed width so far off-screen or negative corners compare correctly
    // before anything is truncated to counter width.
    always_comb begin
        c_x0    = (min_x < 32'sd0) ? 32'sd0 : min_x;
        c_x1    = (max_x > X_MAX)  ? X_MAX  : max_x;
        c_y0    = (min_y < 32'sd0) ? 32'sd0 : min_y;
        c_y1    = (max_y > Y_MAX)  ? Y_MAX  : max_y;
        c_empty = (c_x0 > c_x1) || (c_y0 > c_y1);
        accept  = bbox_valid && bbox_ready;
        xfer    = px_valid && px_ready;
        nx      = px_x + XW'(1);
        ny      = px_y + YW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bbox_ready <= 1'b0;
            px_valid   <= 1'b0;
            px_x       <= '0;
            px_y       <= '0;
            px_last    <= 1'b0;
            done       <= 1'b0;
            x0_r       <= '0;
            x1_r       <= '0;
            y1_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bbox_ready <= 1'b0;
                        if (c_empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // Non-empty guarantees all four limits lie on-screen, so the
                            // truncation to counter width is lossless.
                            state    <= SCAN;
                            x0_r     <= c_x0[XW-1:0];
                            x1_r     <= c_x1[XW-1:0];
                            y1_r     <= c_y1[YW-1:0];
                            px_x     <= c_x0[XW-1:0];
                            px_y     <= c_y0[YW-1:0];
                            px_valid <= 1'b1;
                            px_last  <= (c_x0 == c_x1) && (c_y0 == c_y1);
                        end
                    end else begin
                        bbox_ready <= 1'b1;
                    end
                end

                SCAN: begin
                    if (xfer) begin
                        if (px_x == x1_r) begin
                            if (px_last) begin
                                state    <= DONE;
                                px_valid <= 1'b0;
                                px_last  <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                px_x    <= x0_r;
                                px_y    <= ny;
                                px_last <= (x0_r == x1_r) && (ny == y1_r);
                            end
                        end else begin
                            px_x    <= nx;
                            px_last <= (nx == x1_r) && (px_y == y1_r);
                        end
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    bbox_ready <= 1'b1;
                end

                default: begin
                    state      <= IDLE;
                    px_valid   <= 1'b0;
                    px_last    <= 1'b0;
                    done       <= 1'b0;
                    bbox_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRI_BBOX_SCAN_COUNT_EN
    // Cleared at accept, counts transfers, and holds through DONE/IDLE until the next box.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_count <= '0;
        end else if (accept) begin
            pix_count <= '0;
        end else if (xfer) begin
            pix_count <= pix_count + 32'd1;
        end
    end
`endif

endmodule
